// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter_pkg
// Description : Shared constants and helpers for the BRAM port arbiter and
//               its round-robin sub-arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    // Largest requester count the arbiter is built and checked for.
    localparam int C_MAX_NUM_REQ = 16;

    // Ceiling log2. The result is never below 1, so that a pointer or index
    // built from it is still a legal vector when there is only one requester.
    function automatic int clog2_min1(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Layout of one response-pipeline entry:
    //   bit [num_req]      : is_read
    //   bits [num_req-1:0] : one-hot id of the requester that issued the read
    function automatic int rsp_entry_width(input int num_req);
        return num_req + 1;
    endfunction

endpackage : bram_port_arbiter_pkg
`default_nettype wire

// File: rtl/bram_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter_rr_arbiter
// Description : Purely combinational round-robin priority rotate. Scans the
//               request vector from i_ptr upward, wrapping around, and grants
//               the first asserted request. The result is a one-hot grant and
//               the index of the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter_rr_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    generate
        if (NUM_REQ == 1) begin : g_single
            // With a single requester there is nothing to rotate.
            logic w_unused_ptr;
            assign w_unused_ptr  = ^i_ptr;
            assign o_grant       = i_req;
            assign o_grant_idx   = '0;
            assign o_grant_valid = i_req[0];
        end else begin : g_multi
            localparam logic [PTR_W:0] C_NUM = (PTR_W + 1)'(NUM_REQ);

            logic [2*NUM_REQ-1:0] w_req_dbl;
            logic [NUM_REQ-1:0]   w_req_rot;
            logic [PTR_W-1:0]     w_offset;
            logic                 w_found;
            logic [PTR_W:0]       w_idx_sum;
            logic [PTR_W-1:0]     w_idx;

            // Rotate the doubled request vector so i_ptr lands at bit 0. Find
            // the lowest set bit, then map the offset back to an absolute
            // requester index.
            always_comb begin
                w_req_dbl = {i_req, i_req};
                w_req_rot = NUM_REQ'(w_req_dbl >> i_ptr);
                w_found   = 1'b0;
                w_offset  = '0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!w_found && w_req_rot[k]) begin
                        w_found  = 1'b1;
                        w_offset = PTR_W'(k);
                    end
                end
                w_idx_sum = {1'b0, i_ptr} + {1'b0, w_offset};
                if (w_idx_sum >= C_NUM) begin
                    w_idx_sum = w_idx_sum - C_NUM;
                end
                w_idx          = w_idx_sum[PTR_W-1:0];
                o_grant        = '0;
                o_grant[w_idx] = w_found;
                o_grant_idx    = w_idx;
                o_grant_valid  = w_found;
            end
        end
    endgenerate

endmodule : bram_port_arbiter_rr_arbiter
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Shares one BRAM port among C_NUM_REQ requesters. Arbitration is
//               round-robin with a valid/ready handshake. The winning command
//               is registered onto the RAM port. A latency pipeline steers
//               each read response back to the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int C_NUM_REQ    = 4,
    parameter int C_ADDR_WIDTH = 10,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_RD_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_NUM_REQ-1:0]              req_valid,
    output logic [C_NUM_REQ-1:0]              req_ready,
    input  logic [C_NUM_REQ-1:0]              req_we,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_wdata,
    output logic [C_NUM_REQ-1:0]              rsp_valid,
    output logic [C_DATA_WIDTH-1:0]           rsp_rdata,
    output logic                              bram_en,
    output logic                              bram_we,
    output logic [C_ADDR_WIDTH-1:0]           bram_addr,
    output logic [C_DATA_WIDTH-1:0]           bram_din,
    input  logic [C_DATA_WIDTH-1:0]           bram_dout
);

    localparam int                 C_PTR_W      = clog2_min1(C_NUM_REQ);
    localparam int                 C_PIPE_DEPTH = C_RD_LATENCY + 1;
    localparam int                 C_ENTRY_W    = rsp_entry_width(C_NUM_REQ);
    localparam logic [C_PTR_W-1:0] C_LAST_IDX   = C_PTR_W'(C_NUM_REQ - 1);

    logic [C_PTR_W-1:0]      r_rr_ptr;
    logic [C_PTR_W-1:0]      w_rr_ptr_d;

    logic [C_NUM_REQ-1:0]    w_grant;
    logic [C_PTR_W-1:0]      w_grant_idx;
    logic                    w_grant_valid;

    logic                    w_sel_we;
    logic [C_ADDR_WIDTH-1:0] w_sel_addr;
    logic [C_DATA_WIDTH-1:0] w_sel_wdata;

    logic                    r_bram_en;
    logic                    w_bram_en_d;
    logic                    r_bram_we;
    logic                    w_bram_we_d;
    logic [C_ADDR_WIDTH-1:0] r_bram_addr;
    logic [C_ADDR_WIDTH-1:0] w_bram_addr_d;
    logic [C_DATA_WIDTH-1:0] r_bram_din;
    logic [C_DATA_WIDTH-1:0] w_bram_din_d;

    // Index 0 is the entry for the command on the RAM port this cycle.
    // Index C_PIPE_DEPTH-1 lines up with that command's data on bram_dout.
    logic [C_PIPE_DEPTH-1:0][C_ENTRY_W-1:0] r_rsp_pipe;
    logic [C_ENTRY_W-1:0]                   w_pipe_in;
    logic [C_ENTRY_W-1:0]                   w_pipe_out;

    bram_port_arbiter_rr_arbiter #(
        .NUM_REQ (C_NUM_REQ),
        .PTR_W   (C_PTR_W)
    ) u_rr_arbiter (
        .i_req         (req_valid),
        .i_ptr         (r_rr_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Ready is the raw grant, forced low while reset is held.
    assign req_ready = w_grant & {C_NUM_REQ{rst_n}};

    // Select the winning requester's command fields. The grant is one-hot.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    // Next state: advance the pointer past the winner, load the command, and
    // tag reads for the response pipeline.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr;
        if (w_grant_valid) begin
            w_rr_ptr_d = (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + C_PTR_W'(1);
        end
        w_bram_en_d   = w_grant_valid;
        w_bram_we_d   = w_grant_valid & w_sel_we;
        w_bram_addr_d = w_grant_valid ? w_sel_addr  : r_bram_addr;
        w_bram_din_d  = w_grant_valid ? w_sel_wdata : r_bram_din;
        w_pipe_in     = '0;
        if (w_grant_valid && !w_sel_we) begin
            w_pipe_in = {1'b1, w_grant};
        end
    end

    // State registers. A reset discards every in-flight read tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_rsp_pipe  <= '0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_d;
            r_bram_en   <= w_bram_en_d;
            r_bram_we   <= w_bram_we_d;
            r_bram_addr <= w_bram_addr_d;
            r_bram_din  <= w_bram_din_d;
            r_rsp_pipe  <= {r_rsp_pipe[C_PIPE_DEPTH-2:0], w_pipe_in};
        end
    end

    assign bram_en   = r_bram_en;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;

    assign w_pipe_out = r_rsp_pipe[C_PIPE_DEPTH-1];
    assign rsp_valid  = w_pipe_out[C_NUM_REQ] ? w_pipe_out[C_NUM_REQ-1:0] : '0;
    // The RAM's output register already holds the read data in the cycle the
    // tag arrives. The data is passed through and zeroed when no response is
    // due, so it reads 0 out of reset.
    assign rsp_rdata  = (|rsp_valid) ? bram_dout : '0;

endmodule : bram_port_arbiter
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter. It uses directed
//               scenarios plus a randomized run that is checked against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bram_port_arbiter #(
    parameter int TB_RD_LATENCY = 1
);
    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = TB_RD_LATENCY;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, bram_din, bram_dout;
    logic            bram_en, bram_we;
    logic [AW-1:0]   bram_addr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_port_arbiter #(
        .C_NUM_REQ    (N),
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    // Power-on contents of every RAM word that has not been written yet.
    function automatic logic [DW-1:0] pat(input int a);
        return DW'(32'h5A00_0000 + a * 32'h0001_0101);
    endfunction

    // RAM port model: a synchronous read with LAT output stages.
    bit [DW-1:0] ram    [0:(1<<AW)-1];
    bit          ram_wr [0:(1<<AW)-1];
    bit [DW-1:0] ram_pipe [0:LAT-1];
    always @(posedge clk) begin
        if (bram_en && !bram_we) ram_pipe[0] <= ram_wr[bram_addr] ? ram[bram_addr] : pat(int'(bram_addr));
        if (bram_en && bram_we) begin
            ram[bram_addr]    <= bram_din;
            ram_wr[bram_addr] <= 1'b1;
        end
        for (int k = 1; k < LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign bram_dout = ram_pipe[LAT-1];

    // Reference model: the pointer, a shadow memory, an expected-response
    // queue and the command expected on the port next cycle.
    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          rsp_q[$];
    int            m_ptr;
    bit [DW-1:0]   sh_mem [0:(1<<AW)-1];
    bit            sh_wr  [0:(1<<AW)-1];
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
        end
        return '0;
    endfunction

    task automatic model_commit();
        logic [N-1:0] g;
        rsp_t e;
        g    = model_grant(req_valid, m_ptr);
        m_en = 1'b0;
        m_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                m_en   = 1'b1;
                m_we   = req_we[i];
                m_addr = req_addr[i*AW +: AW];
                m_din  = req_wdata[i*DW +: DW];
                if (req_we[i]) begin
                    sh_mem[m_addr] = m_din;
                    sh_wr[m_addr]  = 1'b1;
                end else begin
                    e.due  = cyc + 1 + LAT;
                    e.id   = i;
                    e.data = sh_wr[m_addr] ? sh_mem[m_addr] : pat(int'(m_addr));
                    rsp_q.push_back(e);
                end
                m_ptr = (i + 1) % N;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        m_ptr = 0; m_en = 1'b0; m_we = 1'b0;
        rsp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int order[5] = '{0, 1, 2, 3, 0};
        req_valid = '1; req_we = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_cmp++; if ({bram_en, bram_we} !== 2'b00) begin n_err++; $display("FAIL reset_en_we got=%b exp=00", {bram_en, bram_we}); end
        n_cmp++; if (bram_addr !== '0 || bram_din !== '0) begin n_err++; $display("FAIL reset_addr_din got=%h/%h exp=0/0", bram_addr, bram_din); end
        n_cmp++; if (rsp_valid !== '0 || rsp_rdata !== '0) begin n_err++; $display("FAIL reset_rsp got=%b/%h exp=0/0", rsp_valid, rsp_rdata); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) begin
                n_cmp++;
                if (req_ready !== (N'(1) << order[k])) begin n_err++; $display("FAIL rr_order k=%0d got=%b exp_idx=%0d", k, req_ready, order[k]); end
            end
            if (k == 0) begin
                n_cmp++; if (bram_en !== 1'b0) begin n_err++; $display("FAIL rr_first_en got=%b exp=0", bram_en); end
            end else begin
                n_cmp++;
                if (bram_en !== 1'b1 || bram_addr !== AW'(order[k-1])) begin n_err++; $display("FAIL rr_cmd k=%0d got en=%b addr=%h exp en=1 addr=%0d", k, bram_en, bram_addr, order[k-1]); end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_write_read();
        int acc;
        logic [N-1:0] exp_v;
        do_reset();
        req_valid = 4'b0100; req_we = 4'b0100;
        req_addr[2*AW +: AW] = 10'h005; req_wdata[2*DW +: DW] = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wr_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0010; req_we = 4'b0000; req_addr[1*AW +: AW] = 10'h005;
        @(negedge clk);
        acc = cyc;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_grant got=%b exp=0010", req_ready); end
        n_cmp++;
        if ({bram_en, bram_we, bram_addr, bram_din} !== {2'b11, 10'h005, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_cmd got en=%b we=%b addr=%h din=%h", bram_en, bram_we, bram_addr, bram_din);
        end
        tick();
        req_valid = '0;
        for (int d = 1; d <= LAT + 2; d++) begin
            @(negedge clk);
            if (d == 1) begin
                n_cmp++;
                if ({bram_en, bram_we, bram_addr} !== {2'b10, 10'h005}) begin n_err++; $display("FAIL rd_cmd got en=%b we=%b addr=%h", bram_en, bram_we, bram_addr); end
            end
            exp_v = (cyc == acc + 1 + LAT) ? 4'b0010 : 4'b0000;
            n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL raw_rsp_valid d=%0d got=%b exp=%b", d, rsp_valid, exp_v); end
            if (exp_v != 0) begin
                n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_rsp_data got=%h exp=deadbeef", rsp_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_single_requester();
        int acc0;
        int d;
        logic [N-1:0] exp_r, exp_v;
        do_reset();
        acc0 = -100;
        for (int t = 0; t < 5 + LAT + 3; t++) begin
            req_valid = (t < 5) ? 4'b1000 : 4'b0000;
            req_we = '0;
            req_addr[3*AW +: AW] = AW'(t);
            @(negedge clk);
            if (t == 0) acc0 = cyc;
            exp_r = (t < 5) ? 4'b1000 : 4'b0000;
            n_cmp++; if (req_ready !== exp_r) begin n_err++; $display("FAIL single_grant t=%0d got=%b exp=%b", t, req_ready, exp_r); end
            d = cyc - acc0 - 1 - LAT;
            exp_v = (d >= 0 && d < 5) ? 4'b1000 : 4'b0000;
            n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL single_rsp_valid t=%0d got=%b exp=%b", t, rsp_valid, exp_v); end
            if (exp_v != 0) begin
                n_cmp++; if (rsp_rdata !== pat(d)) begin n_err++; $display("FAIL single_rsp_data t=%0d got=%h exp=%h", t, rsp_rdata, pat(d)); end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_rr_pointer();
        do_reset();
        req_we = '0;
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ptr_setup got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL ptr_first got=%b exp=1000", req_ready); end
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ptr_second got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b1111;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ptr_end got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        logic [N-1:0] exp_r;
        do_reset();
        req_we = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_r = N'(1) << k;
            n_cmp++; if (req_ready !== exp_r) begin n_err++; $display("FAIL mid_grant k=%0d got=%b exp=%b", k, req_ready, exp_r); end
            tick();
            req_valid = req_valid & ~exp_r;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== '0 || bram_en !== 1'b0) begin n_err++; $display("FAIL mid_quiet k=%0d got rsp=%b en=%b exp 0/0", k, rsp_valid, bram_en); end
            tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001 || bram_en !== 1'b0) begin n_err++; $display("FAIL mid_restart got ready=%b en=%b exp 0001/0", req_ready, bram_en); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (bram_en !== 1'b1 || bram_addr !== 10'h000) begin n_err++; $display("FAIL mid_restart_cmd got en=%b addr=%h exp 1/000", bram_en, bram_addr); end
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        req_valid = 4'b0010; req_we = 4'b0010;
        req_addr[1*AW +: AW] = 10'h030; req_wdata[1*DW +: DW] = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL idle_setup got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0; req_we = '0;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            if (t == 0) begin
                n_cmp++; if ({bram_en, bram_we} !== 2'b11) begin n_err++; $display("FAIL idle_wr got=%b exp=11", {bram_en, bram_we}); end
            end else begin
                n_cmp++;
                if (bram_en !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
                    n_err++; $display("FAIL idle t=%0d got en=%b rsp=%b ready=%b exp 0", t, bram_en, rsp_valid, req_ready);
                end
            end
            tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL idle_ptr got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0]  exp_g, exp_v;
        logic [DW-1:0] exp_d;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (c < 385 && !req_valid[i] && $urandom_range(0, 99) < 60) begin
                    req_valid[i] = 1'b1;
                    req_we[i]    = ($urandom_range(0, 2) == 0);
                    req_addr[i*AW +: AW]  = AW'(32'h100 + $urandom_range(0, 7));
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
            @(negedge clk);
            exp_g = model_grant(req_valid, m_ptr);
            n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
            n_cmp++; if ({bram_en, bram_we} !== {m_en, m_we}) begin n_err++; $display("FAIL rnd_en_we c=%0d got=%b exp=%b", c, {bram_en, bram_we}, {m_en, m_we}); end
            if (m_en) begin
                n_cmp++; if (bram_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bram_addr, m_addr); end
            end
            if (m_we) begin
                n_cmp++; if (bram_din !== m_din) begin n_err++; $display("FAIL rnd_din c=%0d got=%h exp=%h", c, bram_din, m_din); end
            end
            exp_v = '0;
            exp_d = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                exp_v = N'(1) << rsp_q[0].id;
                exp_d = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end
            n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_v); end
            if (exp_v != 0) begin
                n_cmp++; if (rsp_rdata !== exp_d) begin n_err++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_rdata, exp_d); end
            end
            model_commit();
            tick();
            req_valid = req_valid & ~exp_g;
        end
        n_cmp++; if (rsp_q.size() != 0) begin n_err++; $display("FAIL rnd_drain got=%0d pending exp=0", rsp_q.size()); end
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_write_read();
        test_single_requester();
        test_rr_pointer();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bram_port_arbiter
`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of a dual-port block RAM between C_NUM_REQ independent requesters.
- Uses round-robin arbitration with a valid/ready request handshake.
- Registers the winning command onto the RAM port and tracks in-flight reads through a latency pipeline, so each read response is steered back to the requester that issued it.
- Sits between the CNN layer-accelerator datapath clients (weight loaders, row buffers, output writers) and a wide-read BRAM instance.

Parameters:
- C_NUM_REQ, 4: number of requesters; legal range 1–16.
- C_ADDR_WIDTH, 10: RAM port address width.
- C_DATA_WIDTH, 32: RAM port data width, for both read and write.
- C_RD_LATENCY, 1: cycles from a registered RAM command to valid RAM output. Use 1 with no output register, 2 with an output register.

Ports:
- clk  in  1  single clock for the block and the RAM port.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  C_NUM_REQ  per-requester command valid.
- req_ready  out  C_NUM_REQ  per-requester grant/accept.
- req_we  in  C_NUM_REQ  1 = write, 0 = read.
- req_addr  in  C_NUM_REQ*C_ADDR_WIDTH  packed addresses; requester i occupies slice [i*AW +: AW].
- req_wdata  in  C_NUM_REQ*C_DATA_WIDTH  packed write data.
- rsp_valid  out  C_NUM_REQ  one-hot read-data valid.
- rsp_rdata  out  C_DATA_WIDTH  read data, broadcast to all requesters, qualified by rsp_valid.
- bram_en  out  1  RAM port enable.
- bram_we  out  1  RAM port write enable.
- bram_addr  out  C_ADDR_WIDTH  RAM port address.
- bram_din  out  C_DATA_WIDTH  RAM port write data.
- bram_dout  in  C_DATA_WIDTH  RAM port read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rr_ptr = 0.
  - bram_en, bram_we, bram_addr and bram_din = 0.
  - Response pipeline cleared; rsp_valid = 0.
  - rsp_rdata = 0.
  - req_ready = 0 while rst_n is low.
- Arbitration (combinational, every cycle):
  - Scan req_valid starting at index rr_ptr, wrapping modulo C_NUM_REQ; the first asserted index wins.
  - req_ready is one-hot on the winner, or all-zero if no request.
  - req_ready never depends on any requester's own ready. Requesters must hold valid, we, addr and wdata stable until accepted.
- Accept: a command is accepted when req_valid[i] & req_ready[i]. On accept:
  - rr_ptr <= (i+1) mod C_NUM_REQ.
  - With no accept, rr_ptr holds.
- Command register (next clock edge after accept):
  - bram_en = 1.
  - bram_we = req_we[i].
  - bram_addr and bram_din take requester i's slices.
  - With no accept: bram_en = 0 and bram_we = 0. addr/din may hold their last value.
  - Throughput: one command per cycle; back-to-back grants are allowed, including to the same requester when it is the only one requesting.
- Read tracking:
  - A shift pipeline of depth C_RD_LATENCY+1 carries {is_read, one-hot id}.
  - rsp_valid[i] asserts exactly 1 + C_RD_LATENCY cycles after the accept cycle of a read by requester i.
  - rsp_rdata = bram_dout, registered at the same time as rsp_valid.
  - Writes produce no response.
  - Responses cannot be back-pressured; requesters must sink them.
- Hazards:
  - A read following a write to the same address gets the new data; RAM write mode is WRITE_FIRST on the other port only, and same-port ordering is preserved because commands are issued in accept order.
  - Cross-port collisions are the owner's responsibility and are not checked here.
- Reset mid-operation: in-flight reads are discarded, no rsp_valid is issued for them, and arbitration restarts at index 0.
- C_NUM_REQ = 1: the arbiter degenerates to req_ready = req_valid; rr_ptr is constant 0.

Decomposition:
- Shared package/header (math.vh, cnn_layer_accel_defs.vh): clog2 function, C_NUM_REQ limit, and rsp pipeline entry layout (id width = C_NUM_REQ one-hot plus is_read bit).
- One natural sub-module: rr_arbiter (req vector plus rr_ptr in, one-hot grant and grant index out; purely combinational priority rotate). It is reusable by other shared-resource controllers.
- The top level holds rr_ptr, the command register and the response pipeline.

Test Plan:
- Reset with all req_valid = 4'b1111 held → req_ready = 0 during reset; first post-reset grants in order 0, 1, 2, 3, 0, one per cycle; bram_en high every cycle from cycle 1.
- Requester 2 writes 0xDEADBEEF to addr 0x005, then requester 1 reads addr 0x005 → bram_we = 1 then 0 on consecutive cycles; rsp_valid = 4'b0010 with rsp_rdata = 0xDEADBEEF exactly 2 cycles after the read accept (C_RD_LATENCY = 1). Rerun with C_RD_LATENCY = 2 → 3 cycles.
- Only requester 3 asserts valid for 5 cycles with reads of addr 0..4 → granted every cycle; rsp_valid[3] pulses 5 consecutive cycles with data in address order.
- Requesters 0 and 3 both valid, rr_ptr = 1 → requester 3 wins first, then 0; rr_ptr ends at 1.
- Pipelined reads from requesters 0, 1, 2 in flight, then rst_n pulsed low for one cycle → no rsp_valid afterwards; bram_en = 0 until the next accept; next grant starts from index 0.
- Idle (no valid) for 10 cycles → bram_en = 0, rsp_valid = 0, rr_ptr unchanged.
